// File: rtl/hazard_sched_pkg.sv
// Shared types and constants for the hazard scheduler: FSM encoding,
// register-file size and scoreboard counter width.
package hazard_sched_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam int NUM_REGS  = 8;
  localparam int REG_SEL_W = 3;
  localparam int CNT_W     = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/hazard_sched_if.sv
// Decode/write-back/scheduler signal bundle. The pipeline side is the master,
// the scheduler the slave. stall_cnt exists only with HAZARD_STATS_EN.
interface hazard_sched_if import hazard_sched_pkg::*; ();

  logic                 id_valid;
  logic [REG_SEL_W-1:0] id_rs_sel;
  logic [REG_SEL_W-1:0] id_rt_sel;
  logic                 id_rs_used;
  logic                 id_rt_used;
  logic                 id_regWrite;
  logic [REG_SEL_W-1:0] id_write_reg;
  logic                 id_halt;
  logic                 flush;
  logic                 wb_valid;
  logic                 wb_regWrite;
  logic [REG_SEL_W-1:0] wb_write_reg;

  logic                 issue;
  logic                 stall;
  logic                 bubble;
  logic [NUM_REGS-1:0]  busy_mask;
  logic                 halted;
  logic                 sb_err;
`ifdef HAZARD_STATS_EN
  logic [15:0]          stall_cnt;
`endif

  modport master (
    output id_valid, id_rs_sel, id_rt_sel, id_rs_used, id_rt_used,
           id_regWrite, id_write_reg, id_halt, flush,
           wb_valid, wb_regWrite, wb_write_reg,
    input  issue, stall, bubble, busy_mask, halted, sb_err
`ifdef HAZARD_STATS_EN
    , stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs_sel, id_rt_sel, id_rs_used, id_rt_used,
           id_regWrite, id_write_reg, id_halt, flush,
           wb_valid, wb_regWrite, wb_write_reg,
    output issue, stall, bubble, busy_mask, halted, sb_err
`ifdef HAZARD_STATS_EN
    , stall_cnt
`endif
  );

endinterface

// File: rtl/hazard_sched_sb_counter.sv
// One per-register pending-writer counter: saturating up/down, with a
// combinational underflow flag for a lone decrement of an empty counter.
module sb_counter
  import hazard_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  // Simultaneous inc and dec cancel out, so neither edge case applies then.
  assign underflow = dec & ~inc & (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Scoreboard-based issue scheduler with halt drain. HAZARD_STATS_EN adds a
// saturating stall-cycle counter on the interface.
//   state  | meaning
//   RUN    | normal issue, hazards stall decode
//   DRAIN  | halt seen, waiting for all in-flight instructions to retire
//   HALTED | drained and stopped until reset
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input logic           clk,
  input logic           rst,
  hazard_sched_if.slave bus
);

  localparam logic [2:0] INFLIGHT_LIMIT = 3'(MAX_INFLIGHT);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec, dec_vec, uflow_vec, busy;
  logic [2:0]          inflight;
  logic                run, hazard;
  logic                issue_int, stall_int, bubble_int;
  logic                inflight_uflow, sb_err_q;

  assign run = (state == RUN);

  // Only registered counters feed the hazard, so a same-cycle write-back
  // releases the dependent instruction one cycle later.
  always_comb begin
    hazard = (inflight == INFLIGHT_LIMIT);
    if (bus.id_rs_used && (cnt[bus.id_rs_sel] != '0))      hazard = 1'b1;
    if (bus.id_rt_used && (cnt[bus.id_rt_sel] != '0))      hazard = 1'b1;
    if (bus.id_regWrite && (cnt[bus.id_write_reg] == CNT_MAX)) hazard = 1'b1;
  end

  always_comb begin
    issue_int  = 1'b0;
    stall_int  = 1'b0;
    bubble_int = 1'b0;
    if (!rst) begin
      issue_int  = bus.id_valid & run & ~hazard & ~bus.flush & ~bus.id_halt;
      stall_int  = bus.id_valid & run & hazard & ~bus.flush;
      bubble_int = (bus.id_valid & ~issue_int) | ~run;
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    busy    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = issue_int & bus.id_regWrite & (bus.id_write_reg == 3'(r));
      dec_vec[r] = bus.wb_valid & bus.wb_regWrite & (bus.wb_write_reg == 3'(r));
      busy[r]    = (cnt[r] != '0);
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .cnt       (cnt[r]),
      .underflow (uflow_vec[r])
    );
  end

  assign inflight_uflow = bus.wb_valid & ~issue_int & (inflight == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue_int && !bus.wb_valid) begin
      if (inflight != 3'd7) inflight <= inflight + 3'd1;
    end else if (bus.wb_valid && !issue_int) begin
      if (inflight != 3'd0) inflight <= inflight - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_err_q <= 1'b0;
    else if ((|uflow_vec) || inflight_uflow) sb_err_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.id_valid && bus.id_halt && !hazard && !bus.flush) state_nxt = DRAIN;
      DRAIN:   if (inflight == 3'd0) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else if (stall_int && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

  assign bus.issue     = issue_int;
  assign bus.stall     = stall_int;
  assign bus.bubble    = bubble_int;
  assign bus.busy_mask = busy;
  assign bus.halted    = (state == HALTED);
  assign bus.sb_err    = sb_err_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: a sequential vector table for the scoreboard
// paths plus hand-written halt/drain, reset, sb_err and stall-count sequences.
module tb_hazard_sched;

  typedef struct {
    logic       v;
    logic [2:0] rs;
    logic       rsu;
    logic [2:0] rt;
    logic       rtu;
    logic       rw;
    logic [2:0] wr;
    logic       hlt;
    logic       fl;
    logic       wbv;
    logic       wbw;
    logic [2:0] wbr;
    logic       e_iss;
    logic       e_stl;
    logic       e_bub;
    logic [7:0] e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];

  hazard_sched_if bus ();

  hazard_sched #(.MAX_INFLIGHT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t r(logic v, logic [2:0] rs, logic rsu, logic [2:0] rt, logic rtu,
                             logic rw, logic [2:0] wr, logic hlt, logic fl,
                             logic wbv, logic wbw, logic [2:0] wbr,
                             logic iss, logic stl, logic bub, logic [7:0] busy);
    vec_t x;
    x.v = v; x.rs = rs; x.rsu = rsu; x.rt = rt; x.rtu = rtu;
    x.rw = rw; x.wr = wr; x.hlt = hlt; x.fl = fl;
    x.wbv = wbv; x.wbw = wbw; x.wbr = wbr;
    x.e_iss = iss; x.e_stl = stl; x.e_bub = bub; x.e_busy = busy;
    return x;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    bus.id_valid     = x.v;
    bus.id_rs_sel    = x.rs;
    bus.id_rs_used   = x.rsu;
    bus.id_rt_sel    = x.rt;
    bus.id_rt_used   = x.rtu;
    bus.id_regWrite  = x.rw;
    bus.id_write_reg = x.wr;
    bus.id_halt      = x.hlt;
    bus.flush        = x.fl;
    bus.wb_valid     = x.wbv;
    bus.wb_regWrite  = x.wbw;
    bus.wb_write_reg = x.wbr;
  endtask

  // Drive one cycle's inputs and check outputs mid-cycle; leaves time at negedge.
  task automatic exec(vec_t x, string tag);
    drive(x);
    @(negedge clk);
    check({tag, " issue"},  16'(bus.issue),     16'(x.e_iss));
    check({tag, " stall"},  16'(bus.stall),     16'(x.e_stl));
    check({tag, " bubble"}, 16'(bus.bubble),    16'(x.e_bub));
    check({tag, " busy"},   16'(bus.busy_mask), 16'(x.e_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(string tag);
    rst = 1'b1;
    #2;
    check({tag, " rst issue"},  16'(bus.issue),  16'd0);
    check({tag, " rst stall"},  16'(bus.stall),  16'd0);
    check({tag, " rst bubble"}, 16'(bus.bubble), 16'd0);
    check({tag, " rst halted"}, 16'(bus.halted), 16'd0);
    check({tag, " rst sb_err"}, 16'(bus.sb_err), 16'd0);
    check({tag, " rst busy"},   16'(bus.busy_mask), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t idle, clean;
    idle  = r(0,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,8'h00);
    clean = r(1,0,0,0,0, 0,0, 0,0, 0,0,0, 1,0,0,8'h00);

    //          v rs u rt u rw wr h f wv ww wr  iss stl bub busy
    tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,8'h00));
    tbl.push_back(r(1,1,1,2,1, 1,3, 0,0, 0,0,0, 1,0,0,8'h00));
    tbl.push_back(r(1,3,1,0,0, 1,4, 0,0, 0,0,0, 0,1,1,8'h08));
    tbl.push_back(r(1,3,1,0,0, 1,4, 0,0, 1,1,3, 0,1,1,8'h08));
    tbl.push_back(r(1,3,1,0,0, 1,4, 0,0, 0,0,0, 1,0,0,8'h00));
    tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 1,1,4, 0,0,0,8'h10));
    tbl.push_back(r(1,0,0,0,0, 1,2, 0,0, 0,0,0, 1,0,0,8'h00));
    tbl.push_back(r(1,0,0,0,0, 1,2, 0,0, 1,1,2, 1,0,0,8'h04));
    tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 1,1,2, 0,0,0,8'h04));
    tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,8'h00));
    tbl.push_back(r(1,0,0,0,0, 1,5, 0,0, 0,0,0, 1,0,0,8'h00));
    tbl.push_back(r(1,0,0,0,0, 1,5, 0,0, 0,0,0, 1,0,0,8'h20));
    tbl.push_back(r(1,0,0,0,0, 1,5, 0,0, 0,0,0, 1,0,0,8'h20));
    tbl.push_back(r(1,0,0,0,0, 1,5, 0,0, 0,0,0, 0,1,1,8'h20));
    tbl.push_back(r(1,0,0,0,0, 1,5, 0,0, 1,1,5, 0,1,1,8'h20));
    tbl.push_back(r(1,0,0,0,0, 1,5, 0,0, 0,0,0, 1,0,0,8'h20));
    for (int k = 0; k < 3; k++) tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 1,1,5, 0,0,0,8'h20));
    tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,8'h00));
    for (int k = 0; k < 4; k++) tbl.push_back(r(1,0,0,0,0, 0,0, 0,0, 0,0,0, 1,0,0,8'h00));
    tbl.push_back(r(1,0,0,0,0, 0,0, 0,0, 0,0,0, 0,1,1,8'h00));
    tbl.push_back(r(1,0,0,0,0, 0,0, 0,0, 1,0,0, 0,1,1,8'h00));
    tbl.push_back(r(1,0,0,0,0, 0,0, 0,0, 0,0,0, 1,0,0,8'h00));
    for (int k = 0; k < 4; k++) tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 1,0,0, 0,0,0,8'h00));
    tbl.push_back(r(1,0,0,0,0, 1,6, 0,0, 0,0,0, 1,0,0,8'h00));
    tbl.push_back(r(1,6,0,0,0, 0,0, 0,0, 0,0,0, 1,0,0,8'h40));
    tbl.push_back(r(1,0,0,6,1, 0,0, 0,1, 0,0,0, 0,0,1,8'h40));
    tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 1,1,6, 0,0,0,8'h40));
    tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 1,0,0, 0,0,0,8'h00));
    tbl.push_back(r(1,0,0,0,0, 0,0, 0,1, 0,0,0, 0,0,1,8'h00));
    tbl.push_back(r(1,0,0,0,0, 0,0, 1,1, 0,0,0, 0,0,1,8'h00));
    tbl.push_back(r(0,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,8'h00));

    // Reset with a valid instruction presented: outputs must stay low.
    drive(clean);
    reset_pulse("init");
    drive(idle);

    for (int i = 0; i < tbl.size(); i++) begin
      exec(tbl[i], $sformatf("vec%0d", i));
      check($sformatf("vec%0d halted", i), 16'(bus.halted), 16'd0);
      step();
    end

    // Halt with two writers in flight, drain, then halted one cycle after empty.
    exec(r(1,0,0,0,0, 1,1, 0,0, 0,0,0, 1,0,0,8'h00), "h_w1"); step();
    exec(r(1,0,0,0,0, 1,2, 0,0, 0,0,0, 1,0,0,8'h02), "h_w2"); step();
    exec(r(1,0,0,0,0, 0,0, 1,0, 0,0,0, 0,0,1,8'h06), "h_halt");
    check("h_halt halted", 16'(bus.halted), 16'd0); step();
    exec(r(1,0,0,0,0, 0,0, 0,0, 1,1,1, 0,0,1,8'h06), "h_wb1");
    check("h_wb1 halted", 16'(bus.halted), 16'd0); step();
    exec(r(0,0,0,0,0, 0,0, 0,0, 1,1,2, 0,0,1,8'h04), "h_wb2");
    check("h_wb2 halted", 16'(bus.halted), 16'd0); step();
    exec(r(0,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,1,8'h00), "h_empty");
    check("h_empty halted", 16'(bus.halted), 16'd0); step();
    exec(r(1,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,1,8'h00), "h_stop");
    check("h_stop halted", 16'(bus.halted), 16'd1); step();
    reset_pulse("h");
    exec(idle, "h_after");
    check("h_after halted", 16'(bus.halted), 16'd0); step();

    // Reset in the middle of a drain discards tracking.
    exec(r(1,0,0,0,0, 1,3, 0,0, 0,0,0, 1,0,0,8'h00), "d_w3"); step();
    exec(r(1,0,0,0,0, 0,0, 1,0, 0,0,0, 0,0,1,8'h08), "d_halt"); step();
    exec(r(1,3,1,0,0, 0,0, 0,0, 0,0,0, 0,0,1,8'h08), "d_drain"); step();
    drive(idle);
    reset_pulse("d");
    exec(r(1,3,1,0,0, 0,0, 0,0, 0,0,0, 1,0,0,8'h00), "d_after"); step();
    exec(r(0,0,0,0,0, 0,0, 0,0, 1,0,0, 0,0,0,8'h00), "d_ret"); step();

    // Write-back of an empty register sets a sticky error.
    exec(r(0,0,0,0,0, 0,0, 0,0, 1,1,7, 0,0,0,8'h00), "e_wb7");
    check("e_wb7 sb_err", 16'(bus.sb_err), 16'd0); step();
    exec(idle, "e_hold1");
    check("e_hold1 sb_err", 16'(bus.sb_err), 16'd1); step(); step();
    exec(idle, "e_hold2");
    check("e_hold2 sb_err", 16'(bus.sb_err), 16'd1); step();
    drive(idle);
    reset_pulse("e");

    // Five stall cycles behind a writer of r0.
    exec(r(1,0,0,0,0, 1,0, 0,0, 0,0,0, 1,0,0,8'h00), "s_w0"); step();
    for (int k = 0; k < 4; k++) begin
      exec(r(1,0,1,0,0, 0,0, 0,0, 0,0,0, 0,1,1,8'h01), $sformatf("s_stall%0d", k)); step();
    end
    exec(r(1,0,1,0,0, 0,0, 0,0, 1,1,0, 0,1,1,8'h01), "s_stall4"); step();
    exec(r(1,0,1,0,0, 0,0, 0,0, 0,0,0, 1,0,0,8'h00), "s_go");
`ifdef HAZARD_STATS_EN
    check("s_go stall_cnt", bus.stall_cnt, 16'd5);
`endif
    step();
    drive(idle);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
Parameters and macros, one per line: name, default, meaning.
REQ-001 SHALL provide parameter MAX_INFLIGHT, default 4, the maximum number of issued, unretired instructions (1..7).
REQ-002 SHALL provide macro HAZARD_STATS_EN, default undefined, which adds the stall-cycle counter.

Ports, one per line: name, direction, width, meaning.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 id_valid  input  1  decode holds a valid instruction.
REQ-007 id_rs_sel / id_rt_sel  input  3 each  source register selects (instruction[10:8] / [7:5]).
REQ-008 id_rs_used / id_rt_used  input  1 each  the source is actually read.
REQ-009 id_regWrite, id_write_reg  input  1, 3  decode destination.
REQ-010 id_halt  input  1  decode holds a halt instruction.
REQ-011 flush  input  1  taken branch or jump resolved downstream; kills IF and ID.
REQ-012 wb_valid, wb_regWrite, wb_write_reg  input  1, 1, 3  retirement and register write-back.
REQ-013 issue  output  1  the ID instruction advances to EX this cycle.
REQ-014 stall  output  1  hold PC and the IF/ID register.
REQ-015 bubble  output  1  insert a NOP into ID/EX.
REQ-016 busy_mask  output  8  bit r set when register r has a pending writer.
REQ-017 halted, sb_err  output  1 each  halted state; sticky scoreboard underflow.
REQ-018 stall_cnt  output  16  stall-cycle count; present only with HAZARD_STATS_EN.

Function
REQ-019 SHALL keep a 2-bit pending counter per register (8 in total) and a 3-bit inflight counter.
REQ-020 Hazard SHALL be: (id_rs_used and cnt[rs]!=0) or (id_rt_used and cnt[rt]!=0) or (id_regWrite and cnt[dest]==3) or inflight==MAX_INFLIGHT.
REQ-021 The hazard SHALL be evaluated on the registered counters only; a same-cycle write-back does not clear it until the next cycle.
REQ-022 stall SHALL be asserted when id_valid and state==RUN and hazard and not flush.
REQ-023 issue SHALL be asserted when id_valid and state==RUN and not hazard and not flush and not id_halt.
REQ-024 bubble SHALL be asserted whenever id_valid and not issue, and also whenever state is not RUN.
REQ-025 On issue with id_regWrite, cnt[id_write_reg] SHALL increment; on every issue, inflight SHALL increment.
REQ-026 On wb_valid, inflight SHALL decrement; on wb_valid and wb_regWrite, cnt[wb_write_reg] SHALL decrement.
REQ-027 When increment and decrement hit the same counter in one cycle, that counter SHALL be unchanged.
REQ-028 A decrement of a zero counter SHALL leave the counter at 0 and set sb_err, which holds until rst.
REQ-029 busy_mask[r] SHALL equal (cnt[r]!=0), taken from the registered value.
REQ-030 flush SHALL suppress issue and stall in the same cycle; already-issued instructions still retire normally.
REQ-031 The FSM SHALL have three states: RUN, DRAIN and HALTED.
REQ-032 RUN SHALL go to DRAIN when id_valid and id_halt and not hazard and not flush; if flush and halt coincide, flush wins and the FSM stays in RUN.
REQ-033 DRAIN SHALL go to HALTED in the cycle after inflight reaches 0; no issue occurs in DRAIN, and write-backs are still accepted.
REQ-034 HALTED SHALL exit only on rst; halted SHALL be 1 only in HALTED.

Reset
REQ-035 rst SHALL asynchronously clear all counters and sb_err, set the state to RUN, and drive issue, stall and bubble to 0 while rst is held.
REQ-036 Reset mid-drain SHALL discard in-flight tracking; the surrounding pipeline is reset with the block.

Configuration
REQ-037 With HAZARD_STATS_EN defined, stall_cnt SHALL increment on every cycle stall is 1, saturate at 16'hFFFF, and clear on rst.
REQ-038 Without HAZARD_STATS_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10), the register-count constant 8, and the counter width.
REQ-040 A single sub-module, sb_counter, SHALL implement one saturating 2-bit up/down counter with underflow flag and be instantiated 8 times.

Verification
REQ-041 Issue ADD with dest r3, then next cycle an instruction reading r3 (rs) -> stall=1 and bubble=1 until the cycle after wb of r3; busy_mask[3] 1 then 0.
REQ-042 Issue three writers of r5 without retiring, then a fourth writer of r5 -> the fourth stalls with cnt[5]==3; after one wb of r5 it issues.
REQ-043 Issue to r2 and wb of r2 in the same cycle with cnt[2]==1 -> cnt[2] stays 1 and busy_mask[2]=1.
REQ-044 flush asserted while a hazarded instruction sits in ID -> issue=0, stall=0, bubble=1; the pending writer still retires and cnt returns to 0.
REQ-045 Halt in ID with 2 in flight -> DRAIN; two wb_valid pulses -> halted=1 one cycle after inflight==0; rst returns to RUN with halted=0.
REQ-046 wb_regWrite to r7 with cnt[7]==0 -> sb_err=1 and held; with HAZARD_STATS_EN, 5 stall cycles -> stall_cnt==5.
